// File: rtl/serial_word_receiver_pkg.sv
// serial_word_receiver_pkg: shared FSM state type, counter sizing and parity helper for the serial word receiver.
package serial_word_receiver_pkg;
  typedef enum logic {IDLE, RECV} state_e;
  localparam int DEF_WIDTH = 4;
  localparam int CNT_W = $clog2(DEF_WIDTH + 1);
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction
  function automatic logic even_parity(input logic [63:0] word, input logic pbit);
    return (^word ^ pbit) == 1'b0;
  endfunction
endpackage

// File: rtl/serial_word_receiver_if.sv
// serial_word_receiver_if: serial input, programmable pattern and word valid/ready output bundle.
interface serial_word_receiver_if #(parameter int WIDTH = 4);
  logic             start;
  logic             ser_in;
  logic             ser_valid;
  logic [WIDTH-1:0] pattern;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             word_ready;
  logic             match;
  logic             busy;
  logic             overrun;
  logic             parity_err;
  modport master (output start, ser_in, ser_valid, pattern, word_ready,
                  input  word_out, word_valid, match, busy, overrun, parity_err);
  modport slave  (input  start, ser_in, ser_valid, pattern, word_ready,
                  output word_out, word_valid, match, busy, overrun, parity_err);
endinterface

// File: rtl/swr_shift_core.sv
// swr_shift_core: frame shift register and bit counter; frame_o already includes the bit being shifted this cycle.
module swr_shift_core
  import serial_word_receiver_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1,
  parameter int F         = WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic         bit_i,
  output logic [F-1:0] frame_o,
  output logic         done_o
);
  localparam int CW = cnt_w(WIDTH);
  logic [F-1:0]  sh_q, sh_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    frame_o = MSB_FIRST ? {sh_q[F-2:0], bit_i} : {bit_i, sh_q[F-1:1]};
    done_o  = en_i && !clr_i && cnt_q == CW'(F - 1);
    sh_d    = clr_i ? '0 : (en_i ? frame_o : sh_q);
    cnt_d   = (clr_i || done_o) ? '0 : (en_i ? cnt_q + CW'(1) : cnt_q);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/serial_word_receiver.sv
// serial_word_receiver: framed serial-to-word receiver with single-entry valid/ready buffer, pattern match and overrun flag.
// Define SERIAL_WORD_RECEIVER_PARITY_EN to append an even-parity bit to every frame.
module serial_word_receiver
  import serial_word_receiver_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic clk,
  input logic rst_n,
  serial_word_receiver_if.slave bus
);
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
  localparam int F = WIDTH + 1;
`else
  localparam int F = WIDTH;
`endif
  state_e           state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d, word;
  logic             valid_q, valid_d, match_q, match_d, perr_q, perr_d, ovr_q, ovr_d;
  logic [F-1:0]     frame;
  logic             done, cap, drop, acc, perr_cap;
  swr_shift_core #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST), .F(F)) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (bus.start),
    .en_i    (state_q == RECV && bus.ser_valid),
    .bit_i   (bus.ser_in),
    .frame_o (frame),
    .done_o  (done)
  );
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
  // The parity bit is always the last bit on the wire, so its slot depends on shift direction.
  assign word     = MSB_FIRST ? frame[F-1:1] : frame[F-2:0];
  assign perr_cap = !even_parity(64'(word), MSB_FIRST ? frame[0] : frame[F-1]);
`else
  assign word     = frame;
  assign perr_cap = 1'b0;
`endif
  always_comb begin
    state_d = bus.start ? RECV : state_q;
    cap     = done && (!valid_q || bus.word_ready);
    drop    = done && valid_q && !bus.word_ready;
    acc     = !cap && valid_q && bus.word_ready;
    word_d  = cap ? word : word_q;
    valid_d = cap ? 1'b1 : (acc ? 1'b0 : valid_q);
    match_d = cap ? (word == bus.pattern) : (acc ? 1'b0 : match_q);
    perr_d  = cap ? perr_cap : (acc ? 1'b0 : perr_q);
    ovr_d   = bus.start ? 1'b0 : (drop ? 1'b1 : ovr_q);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      valid_q <= 1'b0;
      match_q <= 1'b0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      match_q <= match_d;
      perr_q  <= perr_d;
      ovr_q   <= ovr_d;
    end
  end
  assign bus.word_out   = word_q;
  assign bus.word_valid = valid_q;
  assign bus.match      = match_q;
  assign bus.parity_err = perr_q;
  assign bus.overrun    = ovr_q;
  assign bus.busy       = state_q == RECV;
endmodule

// File: tb/tb_serial_word_receiver.sv
// tb_serial_word_receiver: MSB-first and LSB-first receivers driven in lockstep and checked against a bit-queue reference model.
module tb_serial_word_receiver;
  localparam int W = 4;
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
  localparam int F = W + 1;
`else
  localparam int F = W;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  serial_word_receiver_if #(.WIDTH(W)) if_m ();
  serial_word_receiver_if #(.WIDTH(W)) if_l ();
  serial_word_receiver #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst_n(rst_n), .bus(if_m));
  serial_word_receiver #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst_n(rst_n), .bus(if_l));
  int checks = 0;
  int errors = 0;
  bit q[$];
  logic m_busy, m_valid, m_ovr, m_perr;
  logic [W-1:0] m_word[2];
  logic m_match[2];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_all();
    check("word_m", 32'(if_m.word_out), 32'(m_word[0]));
    check("word_l", 32'(if_l.word_out), 32'(m_word[1]));
    check("match_m", 32'(if_m.match), 32'(m_match[0]));
    check("match_l", 32'(if_l.match), 32'(m_match[1]));
    check("valid_m", 32'(if_m.word_valid), 32'(m_valid));
    check("valid_l", 32'(if_l.word_valid), 32'(m_valid));
    check("busy", 32'({if_m.busy, if_l.busy}), 32'({m_busy, m_busy}));
    check("overrun", 32'({if_m.overrun, if_l.overrun}), 32'({m_ovr, m_ovr}));
    check("parity_err", 32'({if_m.parity_err, if_l.parity_err}), 32'({m_perr, m_perr}));
  endtask
  task automatic model_reset();
    q.delete();
    m_busy = 0; m_valid = 0; m_ovr = 0; m_perr = 0;
    m_word[0] = '0; m_word[1] = '0; m_match[0] = 0; m_match[1] = 0;
  endtask
  function automatic logic [W-1:0] assemble(input bit msb);
    logic [W-1:0] w = '0;
    for (int i = 0; i < W; i++) begin
      if (msb) w[W-1-i] = q[i];
      else w[i] = q[i];
    end
    return w;
  endfunction
  task automatic drive(input logic st, input logic sv, input logic si, input logic rdy, input logic [W-1:0] pat);
    if_m.start = st; if_m.ser_valid = sv; if_m.ser_in = si; if_m.word_ready = rdy; if_m.pattern = pat;
    if_l.start = st; if_l.ser_valid = sv; if_l.ser_in = si; if_l.word_ready = rdy; if_l.pattern = pat;
  endtask
  task automatic step(input logic st, input logic sv, input logic si, input logic rdy, input logic [W-1:0] pat);
    logic done = 0;
    logic np = 0;
    logic [W-1:0] nw[2];
    drive(st, sv, si, rdy, pat);
    if (st) begin
      m_busy = 1; q.delete(); m_ovr = 0;
    end else if (m_busy && sv) begin
      q.push_back(si);
      if (q.size() == F) begin
        done = 1;
        nw[0] = assemble(1);
        nw[1] = assemble(0);
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
        foreach (q[i]) np ^= q[i];
`endif
        q.delete();
      end
    end
    if (done && (!m_valid || rdy)) begin
      m_valid = 1; m_perr = np;
      for (int k = 0; k < 2; k++) begin
        m_word[k] = nw[k];
        m_match[k] = nw[k] == pat;
      end
    end else if (done) m_ovr = 1;
    else if (m_valid && rdy) begin
      m_valid = 0; m_perr = 0; m_match[0] = 0; m_match[1] = 0;
    end
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask
  task automatic send_word(input logic [W-1:0] w, input logic rdy, input logic [W-1:0] pat, input bit gaps);
    for (int i = W - 1; i >= 0; i--) begin
      if (gaps) step(0, 0, 1, rdy, pat);
      step(0, 1, w[i], rdy, pat);
    end
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
    step(0, 1, ^w, rdy, pat);
`endif
  endtask
  task automatic do_reset();
    #2 rst_n = 1'b0;
    drive(0, 0, 0, 0, '0);
    model_reset();
    #1 check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    drive(0, 0, 0, 0, '0);
    model_reset();
    #1 check_all();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 0, 0, 4'b1011);
    send_word(4'b1011, 0, 4'b1011, 0);
    check("t1_word_m", 32'(if_m.word_out), 32'h b);
    check("t1_match_m", 32'(if_m.match), 32'h1);
    check("t1_word_l", 32'(if_l.word_out), 32'h d);
    check("t1_match_l", 32'(if_l.match), 32'h0);
    step(0, 0, 0, 1, '0);
    send_word(4'b0110, 1, '0, 1);
    send_word(4'b0001, 1, '0, 1);
    check("gap_valid", 32'(if_m.word_valid), 32'h1);
    check("gap_word", 32'(if_m.word_out), 32'h1);
    step(0, 0, 0, 1, '0);
    check("gap_drain", 32'(if_m.word_valid), 32'h0);
    send_word(4'b1010, 0, '0, 0);
    send_word(4'b0110, 0, '0, 0);
    check("ovr_word", 32'(if_m.word_out), 32'ha);
    check("ovr_set", 32'(if_m.overrun), 32'h1);
    step(1, 0, 0, 1, '0);
    check("ovr_clr", 32'(if_m.overrun), 32'h0);
    step(0, 1, 0, 1, '0);
    step(0, 1, 0, 1, '0);
    step(1, 0, 0, 1, '0);
    send_word(4'b1111, 1, 4'b1111, 0);
    check("restart_word", 32'(if_m.word_out), 32'hf);
    check("restart_match", 32'(if_m.match), 32'h1);
    step(0, 1, 1, 1, '0);
    do_reset();
    check("rst_word", 32'(if_m.word_out), 32'h0);
    step(1, 0, 0, 0, '0);
    send_word(4'b0101, 0, 4'b0101, 0);
    check("fresh_word", 32'(if_m.word_out), 32'h5);
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
    step(0, 0, 0, 1, '0);
    for (int i = 3; i >= 0; i--) step(0, 1, i != 2, 0, '0);
    step(0, 1, 0, 0, '0);
    check("par_bad", 32'(if_m.parity_err), 32'h1);
    step(0, 0, 0, 1, '0);
    for (int i = 3; i >= 0; i--) step(0, 1, i != 2, 0, '0);
    step(0, 1, 1, 0, '0);
    check("par_good", 32'(if_m.parity_err), 32'h0);
`endif
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      step($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7, 1'($urandom),
           $urandom_range(0, 1) == 1, 4'($urandom_range(0, 3) == 0 ? 0 : $urandom));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_word_receiver.md
Name: serial_word_receiver

Overview:
- Downstream consumer of the parallel-in/serial-out shift-register stage.
- Collects a qualified serial bit stream into WIDTH-bit words and presents each completed word on a single-entry output buffer with a valid/ready handshake.
- Compares every completed word against a programmable pattern and flags overrun.
- Replaces the free-running serial comparators with a framed, counted, reset-safe receiver.

Parameters:
- WIDTH, 4, data bits per word; must be at least 2.
- MSB_FIRST, 1, 1 = the first received bit lands in word_out[WIDTH-1]; 0 = the first received bit lands in word_out[0].

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins framing and discards any partial word.
- ser_in  in  1  serial data bit.
- ser_valid  in  1  ser_in is sampled only when this is 1 (chip-select role).
- pattern  in  WIDTH  compare value, sampled on the edge that completes a word.
- word_out  out  WIDTH  last completed word.
- word_valid  out  1  word_out holds an unconsumed word.
- word_ready  in  1  consumer accepts word_out when word_valid && word_ready.
- match  out  1  word_out == pattern at capture; valid only while word_valid=1.
- busy  out  1  FSM is in RECV.
- overrun  out  1  sticky; a completed word was dropped because the buffer was full.
- parity_err  out  1  see Optional Feature.

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, bit_cnt=0, shift register=0, word_out=0, word_valid=0, match=0, overrun=0, parity_err=0, busy=0.
- FSM states:
  - IDLE: ser_valid is ignored. start -> RECV; bit_cnt=0; overrun cleared.
  - RECV: each cycle with ser_valid=1 shifts ser_in in according to MSB_FIRST and increments bit_cnt. When bit_cnt reaches WIDTH-1 with ser_valid=1, the word completes and bit_cnt wraps to 0. Reception is continuous and RECV stays active.
  - start while in RECV: bit_cnt=0 and the partial word is discarded. If that same cycle would have completed a word, start wins and nothing is captured. overrun is cleared. word_out/word_valid are untouched.
- Completion, when the buffer is free (word_valid=0) or being drained the same cycle (word_ready=1):
  - word_out <= assembled word; word_valid <= 1; match <= (assembled == pattern).
  - Latency: these are visible the cycle after the edge that sampled the last bit.
- Completion with word_valid=1 and word_ready=0: the new word is dropped, overrun <= 1, and word_out/match keep the old value.
- Handshake:
  - word_valid=1 && word_ready=1 with no completion in that cycle: word_valid <= 0 and match <= 0.
  - word_out holds its last value after acceptance.
  - word_ready while word_valid=0 has no effect.
- ser_valid=0 cycles stall the counter. There is no timeout.
- Mid-operation reset: everything returns to reset values immediately, with no partial output.
- pattern changes between completions have no effect on the current match.

Optional Feature:
- Macro: SERIAL_WORD_RECEIVER_PARITY_EN.
- With the macro defined:
  - Each frame is WIDTH data bits followed by one even-parity bit (XOR of data bits and parity bit must be 0); bit_cnt counts to WIDTH.
  - parity_err is captured with the word, following the same drop and overrun rules as match, and is cleared on acceptance.
  - A parity-failing word is still delivered.
- Without the macro: frames are WIDTH bits and parity_err is constant 0.

Decomposition:
- Package serial_word_receiver_pkg:
  - state enum {IDLE, RECV}.
  - Function even_parity(word, pbit).
  - Localparam CNT_W = $clog2(WIDTH+1).
- Sub-module swr_shift_core: shift register plus bit counter, with a clear input, a shift-enable input, and a done pulse. The top level owns the FSM, output buffer, compare and flags.

Test Plan:
- Reset, start, then serial bits 1,0,1,1 with ser_valid=1 (WIDTH=4, MSB_FIRST=1), pattern=4'b1011, word_ready=0 -> cycle after the 4th bit: word_out=4'b1011, word_valid=1, match=1, overrun=0.
- Same stream with MSB_FIRST=0, pattern=4'b1011 -> word_out=4'b1101, match=0.
- Bits interleaved with ser_valid=0 gaps, word_ready held 1 -> word_valid pulses one cycle per word; a second word 0,0,0,1 gives word_out=4'b0001.
- word_ready=0 through two complete words (1010, then 0110) -> word_out stays 4'b1010, overrun=1 after the second word; start pulse -> overrun=0.
- start asserted after 2 of 4 bits, then bits 1,1,1,1 -> a single word 4'b1111; the partial bits never appear.
- rst_n driven low mid-word, then released and restarted -> all outputs 0; the next word is assembled from fresh bits. With SERIAL_WORD_RECEIVER_PARITY_EN: frame 1,0,1,1 plus parity bit 0 -> parity_err=1; with parity bit 1 -> parity_err=0.
